// File: rtl/cpu_pkg.sv
// Shared types and default widths for the pipeline hazard/forwarding controller.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_REG_AW = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PUSH_PC    = 2'd1,
    PUSH_FLAGS = 2'd2,
    VECTOR     = 2'd3
  } int_state_t;

endpackage

// File: rtl/pipeline_hazard_unit_fwd_mux.sv
// Priority forwarding select for one EX operand; stage 0 (youngest) wins.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_AW     = DEF_REG_AW,
  parameter int unsigned FWD_STAGES = 2
) (
  input  logic [REG_AW-1:0]            src,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_dst,
  input  logic [FWD_STAGES-1:0]        fwd_wb,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0]            rf_data,
  output logic [DATA_W-1:0]            op_out
);

  logic found;

  always_comb begin
    op_out = rf_data;
    found  = 1'b0;
    for (int unsigned i = 0; i < FWD_STAGES; i++) begin
      if (!found && fwd_wb[i] && (fwd_dst[i*REG_AW +: REG_AW] == src)) begin
        op_out = fwd_data[i*DATA_W +: DATA_W];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding, branch-flush and interrupt-entry controller.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipeline_hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_AW     = DEF_REG_AW,
  parameter int unsigned FWD_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REG_AW-1:0]            id_src1,
  input  logic [REG_AW-1:0]            id_src2,
  input  logic                         id_src1_used,
  input  logic                         id_src2_used,
  input  logic [REG_AW-1:0]            ex_dst,
  input  logic                         ex_mem_read,
  input  logic [REG_AW-1:0]            ex_src1,
  input  logic [REG_AW-1:0]            ex_src2,
  input  logic [DATA_W-1:0]            rf_data1,
  input  logic [DATA_W-1:0]            rf_data2,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_dst,
  input  logic [FWD_STAGES-1:0]        fwd_wb,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic                         branch_taken,
  input  logic                         interrupt,
  output logic [DATA_W-1:0]            op1_out,
  output logic [DATA_W-1:0]            op2_out,
  output logic                         stall_fetch,
  output logic                         stall_decode,
  output logic                         bubble_ex,
  output logic                         flush_fd,
  output logic                         flush_de,
  output logic                         int_push_pc,
  output logic                         int_push_flags,
  output logic                         int_vector_load,
  output logic                         int_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]                  stall_count,
  output logic [15:0]                  flush_count
`endif
);

  int_state_t state_q, state_d;
  logic       pending_q, pending_d;
  logic       lu, br, hz_stall, fsm_flush, fsm_stall;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_fwd1 (
    .src(ex_src1), .fwd_dst(fwd_dst), .fwd_wb(fwd_wb), .fwd_data(fwd_data),
    .rf_data(rf_data1), .op_out(op1_out)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_fwd2 (
    .src(ex_src2), .fwd_dst(fwd_dst), .fwd_wb(fwd_wb), .fwd_data(fwd_data),
    .rf_data(rf_data2), .op_out(op2_out)
  );

  // Hazard terms are masked while reset is held so every control output reads 0.
  always_comb begin
    lu = reset && ex_mem_read &&
         ((id_src1_used && (id_src1 == ex_dst)) || (id_src2_used && (id_src2 == ex_dst)));
    br       = reset && branch_taken;
    hz_stall = lu && !br;
  end

  always_comb begin
    state_d         = state_q;
    fsm_flush       = 1'b0;
    fsm_stall       = 1'b0;
    int_push_pc     = 1'b0;
    int_push_flags  = 1'b0;
    int_vector_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q && !lu && !br) state_d = PUSH_PC;
      end
      PUSH_PC: begin
        int_push_pc = 1'b1;
        fsm_flush   = 1'b1;
        fsm_stall   = 1'b1;
        state_d     = PUSH_FLAGS;
      end
      PUSH_FLAGS: begin
        int_push_flags = 1'b1;
        fsm_stall      = 1'b1;
        state_d        = VECTOR;
      end
      VECTOR: begin
        int_vector_load = 1'b1;
        fsm_stall       = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A request seen on the entry edge re-arms pending rather than being lost.
    if (interrupt)                                  pending_d = 1'b1;
    else if (state_q == IDLE && state_d == PUSH_PC) pending_d = 1'b0;
    else                                            pending_d = pending_q;

    int_busy     = (state_q != IDLE);
    stall_fetch  = hz_stall || fsm_stall;
    stall_decode = hz_stall;
    bubble_ex    = hz_stall;
    flush_fd     = br || fsm_flush;
    flush_de     = br || fsm_flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (hz_stall && stall_count_q != '1) stall_count_d = stall_count_q + 16'd1;
    if (flush_fd && flush_count_q != '1) flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the next-generation pipelined core.
- Resolves EX operands from N forwarding stages; youngest stage wins.
- Detects load-use hazards and generates stall/bubble.
- Resolves branch flushes.
- Runs a multi-cycle interrupt entry sequence (push PC, push flags, load vector).
- Sits between decode/EX buffers and fetch/memory; replaces ad-hoc forwarding in the ALU stage.

Parameters:
DATA_W, 16, operand width
REG_AW, 3, register address width (2**REG_AW registers, all general, none hardwired)
FWD_STAGES, 2, number of forwarding sources; index 0 = youngest (EX/MEM), index FWD_STAGES-1 = oldest (MEM/WB)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_src1, id_src2  in  REG_AW  source regs of instruction in decode
id_src1_used, id_src2_used  in  1  decode actually reads that source
ex_dst  in  REG_AW  destination of instruction in EX
ex_mem_read  in  1  instruction in EX is a load/pop
ex_src1, ex_src2  in  REG_AW  sources of instruction in EX
rf_data1, rf_data2  in  DATA_W  buffered register-file operands for EX
fwd_dst  in  FWD_STAGES*REG_AW  packed destinations per stage
fwd_wb  in  FWD_STAGES  write-back enable per stage
fwd_data  in  FWD_STAGES*DATA_W  packed result per stage
branch_taken  in  1  EX resolved a taken jump
interrupt  in  1  external interrupt request, level, sampled each edge
op1_out, op2_out  out  DATA_W  forwarded EX operands
stall_fetch, stall_decode  out  1  hold PC / IF-ID buffer
bubble_ex  out  1  insert NOP into ID-EX buffer
flush_fd, flush_de  out  1  squash IF-ID / ID-EX buffers
int_push_pc, int_push_flags, int_vector_load  out  1  interrupt sequence strobes to memory/fetch
int_busy  out  1  interrupt FSM not IDLE

Behaviour:
Forwarding (combinational, zero latency):
- op1_out = fwd_data[i] for the lowest i with fwd_wb[i] && fwd_dst[i]==ex_src1; otherwise rf_data1.
- op2_out is resolved the same way using ex_src2.

Load-use hazard (combinational):
- lu = ex_mem_read && ((id_src1_used && id_src1==ex_dst) || (id_src2_used && id_src2==ex_dst)).
- When lu is set: stall_fetch=stall_decode=bubble_ex=1 for exactly one cycle. The load then leaves EX and lu drops naturally.

Branch:
- branch_taken sets flush_fd=flush_de=1 in the same cycle.
- Flush overrides stall: when branch_taken and lu coincide, stall_*=0 and bubble_ex=0.

Interrupt FSM, states IDLE, PUSH_PC, PUSH_FLAGS, VECTOR:
- pending register: set when interrupt=1; cleared on entry to PUSH_PC.
- IDLE -> PUSH_PC when pending && !lu && !branch_taken; otherwise stay in IDLE.
- PUSH_PC -> PUSH_FLAGS -> VECTOR -> IDLE unconditionally, one cycle each.
- Moore outputs:
  - PUSH_PC: int_push_pc=1, flush_fd=flush_de=1.
  - PUSH_FLAGS: int_push_flags=1.
  - VECTOR: int_vector_load=1.
  - stall_fetch=1 in all three states.
  - int_busy=1 whenever state is not IDLE.
- No nesting: an interrupt arriving while int_busy sets pending and is serviced after returning to IDLE.
- Entry latency is 1 cycle after pending is set, provided no hazard or branch is present.

Reset (async, active-low):
- state=IDLE, pending=0.
- All strobes, stall, flush and bubble outputs are 0.
- op*_out track rf_data*, because forwarding is combinational.
- Reset mid-sequence aborts the sequence immediately with no partial strobes after deassertion.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs stall_count and flush_count, each 16 bits.
  - stall_count increments on each cycle with lu && !branch_taken.
  - flush_count increments on each cycle with flush_fd=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither port nor counters exist.

Decomposition:
- Shared package cpu_pkg:
  - int_state_t enum (IDLE, PUSH_PC, PUSH_FLAGS, VECTOR).
  - Default widths DATA_W and REG_AW.
- One sub-module fwd_mux: parametrised priority select over FWD_STAGES for one operand, instantiated twice.

Test Plan:
- Forwarding priority: ex_src1=3; stage0 dst=3 wb=1 data=16'h00AA; stage1 dst=3 wb=1 data=16'h00BB; rf_data1=16'h1111 -> op1_out=16'h00AA. Drop stage0 wb -> op1_out=16'h00BB. Drop both -> 16'h1111.
- Load-use: ex_mem_read=1, ex_dst=2, id_src2=2, id_src2_used=1 -> stall_fetch=stall_decode=bubble_ex=1 for one cycle. With id_src2_used=0 -> all stay 0.
- Branch vs stall: assert lu and branch_taken in the same cycle -> flush_fd=flush_de=1, stall_fetch=0, bubble_ex=0.
- Interrupt sequence: pulse interrupt for 1 cycle with no hazards -> next three cycles show int_push_pc, int_push_flags, int_vector_load in order; int_busy=1 for exactly 3 cycles.
- Interrupt during sequence: second pulse during PUSH_FLAGS -> after VECTOR, one IDLE cycle, then a second full 3-cycle sequence.
- Reset mid-sequence: drive reset=0 in PUSH_FLAGS -> all strobes 0 immediately. After release, no VECTOR strobe and int_busy=0.
